// File: rtl/count_cmd_seq_pkg.sv
// Shared types and default widths for the count_cmd_seq command sequencer.
package count_seq_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 4;
    localparam int RUN_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    typedef struct packed {
        logic                  mode;
        logic [DATA_W_DEF-1:0] value;
        logic [RUN_W_DEF-1:0]  run;
    } cmd_t;

endpackage

// File: rtl/count_cmd_seq_if.sv
// Command port and counter-drive outputs of the count_cmd_seq sequencer.
interface count_cmd_seq_if #(
    parameter int DATA_W = count_seq_pkg::DATA_W_DEF,
    parameter int RUN_W  = count_seq_pkg::RUN_W_DEF
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_mode;
    logic [DATA_W-1:0] cmd_value;
    logic [RUN_W-1:0]  cmd_run;
    logic [DATA_W-1:0] data_in;
    logic              load;
    logic              mode;
    logic              busy;

    modport master (
        output cmd_valid, cmd_mode, cmd_value, cmd_run,
        input  cmd_ready, data_in, load, mode, busy
    );

    modport slave (
        input  cmd_valid, cmd_mode, cmd_value, cmd_run,
        output cmd_ready, data_in, load, mode, busy
    );
endinterface

// File: rtl/count_cmd_fifo.sv
// Synchronous command FIFO; an extra pointer bit separates full from empty.
module count_cmd_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  T     wdata,
    output T     rdata,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    T           mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        do_push;
    logic        do_pop;

    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/count_cmd_seq.sv
// Command sequencer driving a loadable up/down counter (load, data_in, mode).
// Optional completion counter cmd_done_cnt enabled by COUNT_SEQ_DONECNT_EN.
//   state | meaning
//   IDLE  | no command active, load=0, data_in/mode held
//   LOAD  | load=1 for one cycle with the popped command's value/mode
//   RUN   | free counting, run_cnt counts down to 1
module count_cmd_seq
    import count_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int RUN_W  = RUN_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    count_cmd_seq_if.slave  bus
`ifdef COUNT_SEQ_DONECNT_EN
    ,
    output logic [15:0]     cmd_done_cnt
`endif
);
    cmd_t              wdata;
    cmd_t              rdata;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              last;
    state_e            state;
    logic [RUN_W-1:0]  run_cnt;
    logic [DATA_W-1:0] data_q;
    logic              load_q;
    logic              mode_q;

    assign wdata = '{mode: bus.cmd_mode, value: bus.cmd_value, run: bus.cmd_run};
    assign push  = bus.cmd_valid && !full;

    count_cmd_fifo #(.DEPTH(DEPTH), .T(cmd_t)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .full  (full),
        .empty (empty)
    );

    // Final cycle of the active command; the next one is popped here so
    // consecutive commands run without a gap.
    assign last = ((state == LOAD) && (run_cnt == '0)) ||
                  ((state == RUN) && (run_cnt == RUN_W'(1)));
    assign pop  = !empty && ((state == IDLE) || last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            run_cnt <= '0;
            data_q  <= '0;
            load_q  <= 1'b0;
            mode_q  <= 1'b0;
        end else if (pop) begin
            state   <= LOAD;
            load_q  <= 1'b1;
            data_q  <= rdata.value;
            mode_q  <= rdata.mode;
            run_cnt <= rdata.run;
        end else begin
            load_q <= 1'b0;
            case (state)
                IDLE: state <= IDLE;
                LOAD: state <= (run_cnt != '0) ? RUN : IDLE;
                RUN: begin
                    if (run_cnt == RUN_W'(1)) state <= IDLE;
                    else run_cnt <= run_cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = !full;
    assign bus.data_in   = data_q;
    assign bus.load      = load_q;
    assign bus.mode      = mode_q;
    assign bus.busy      = (state != IDLE);

`ifdef COUNT_SEQ_DONECNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cmd_done_cnt <= '0;
        else if (last) cmd_done_cnt <= cmd_done_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_count_cmd_seq.sv
// Directed bench for count_cmd_seq: single-command table, back-to-back,
// backpressure, reset mid-run and a counter reference over a long stream.
module tb_count_cmd_seq;
    import count_seq_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    count_cmd_seq_if bus ();
`ifdef COUNT_SEQ_DONECNT_EN
    logic [15:0] done_cnt;
`endif

    count_cmd_seq #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef COUNT_SEQ_DONECNT_EN
        ,
        .cmd_done_cnt (done_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load-pulse log and counter reference
    int          lg_cyc[$];
    logic [15:0] lg_dat[$];
    logic        lg_mode[$];
    logic        wrap_on = 1'b0;
    logic [15:0] cnt_model = 16'd0;
    logic [15:0] wexp[$];
    int          widx = 0;

    always @(negedge clk) begin
        if (bus.load) begin
            lg_cyc.push_back(cyc);
            lg_dat.push_back(bus.data_in);
            lg_mode.push_back(bus.mode);
        end
        if (wrap_on && bus.busy) begin
            if (bus.load) cnt_model = bus.data_in;
            else if (bus.mode) cnt_model = cnt_model + 16'd1;
            else cnt_model = cnt_model - 16'd1;
            if (widx < wexp.size()) chk("wrap_cnt", 32'(cnt_model), 32'(wexp[widx]));
            widx++;
        end
    end

    task automatic clear_log();
        lg_cyc.delete();
        lg_dat.delete();
        lg_mode.delete();
    endtask

    task automatic push_cmd(input logic m, input logic [15:0] v, input logic [7:0] r,
                            output int acc_edge);
        logic acc;
        int   n;
        bus.cmd_valid = 1'b1;
        bus.cmd_mode  = m;
        bus.cmd_value = v;
        bus.cmd_run   = r;
        n = 0;
        do begin
            acc = bus.cmd_ready;
            tick();
            n++;
        end while (!acc && n < 500);
        bus.cmd_valid = 1'b0;
        acc_edge = cyc;
        if (!acc) chk("push_timeout", 32'(acc), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (bus.busy && n < budget) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    typedef struct {
        logic        m;
        logic [15:0] v;
        logic [7:0]  r;
        logic [15:0] exp_d;
        logic        exp_m;
        int          exp_runs;
    } vec_t;

    vec_t vt[4];

    initial begin
        int   acc_e;
        int   n;
        int   a0;
        int   n_acc;
        int   blocked_at;
        logic [15:0] base;
        logic [7:0]  runs[12];
        logic [15:0] bp_val[6];
        logic [7:0]  bp_run[6];

        vt[0] = '{m: 1'b1, v: 16'h1234, r: 8'd3, exp_d: 16'h1234, exp_m: 1'b1, exp_runs: 3};
        vt[1] = '{m: 1'b0, v: 16'h0001, r: 8'd0, exp_d: 16'h0001, exp_m: 1'b0, exp_runs: 0};
        vt[2] = '{m: 1'b1, v: 16'hFFFF, r: 8'd1, exp_d: 16'hFFFF, exp_m: 1'b1, exp_runs: 1};
        vt[3] = '{m: 1'b0, v: 16'h8000, r: 8'd5, exp_d: 16'h8000, exp_m: 1'b0, exp_runs: 5};

        bus.cmd_valid = 1'b0;
        bus.cmd_mode  = 1'b0;
        bus.cmd_value = 16'h0;
        bus.cmd_run   = 8'h0;

        #12;
        chk("rst_data", 32'(bus.data_in), 32'h0);
        chk("rst_load", 32'(bus.load), 32'h0);
        chk("rst_mode", 32'(bus.mode), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_ready", 32'(bus.cmd_ready), 32'h1);
`ifdef COUNT_SEQ_DONECNT_EN
        chk("rst_done", 32'(done_cnt), 32'h0);
`endif
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Single commands into an idle sequencer
        for (int i = 0; i < 4; i++) begin
            push_cmd(vt[i].m, vt[i].v, vt[i].r, acc_e);
            chk("single_lat_k", 32'(bus.load), 32'd0);
            tick();
            chk("single_load", 32'(bus.load), 32'd1);
            chk("single_data", 32'(bus.data_in), 32'(vt[i].exp_d));
            chk("single_mode", 32'(bus.mode), 32'(vt[i].exp_m));
            n = 0;
            tick();
            while (bus.busy && n < 300) begin
                if (bus.load) chk("single_extra_load", 32'(bus.load), 32'd0);
                n++;
                tick();
            end
            chk("single_runs", 32'(n), 32'(vt[i].exp_runs));
            tick();
            chk("idle_data_hold", 32'(bus.data_in), 32'(vt[i].exp_d));
            chk("idle_mode_hold", 32'(bus.mode), 32'(vt[i].exp_m));
            chk("idle_load", 32'(bus.load), 32'd0);
        end

        // Back-to-back: load pulses at relative 0, 3, 4
        clear_log();
`ifdef COUNT_SEQ_DONECNT_EN
        base = done_cnt;
`endif
        push_cmd(1'b1, 16'h0010, 8'd2, a0);
        push_cmd(1'b0, 16'hFFFF, 8'd0, acc_e);
        push_cmd(1'b1, 16'h0000, 8'd1, acc_e);
        wait_idle(50);
        chk("b2b_pulses", 32'(lg_cyc.size()), 32'd3);
        if (lg_cyc.size() == 3) begin
            chk("b2b_latency", 32'(lg_cyc[0] - a0), 32'd1);
            chk("b2b_gap1", 32'(lg_cyc[1] - lg_cyc[0]), 32'd3);
            chk("b2b_gap2", 32'(lg_cyc[2] - lg_cyc[0]), 32'd4);
            chk("b2b_d0", 32'(lg_dat[0]), 32'h0010);
            chk("b2b_d1", 32'(lg_dat[1]), 32'hFFFF);
            chk("b2b_d2", 32'(lg_dat[2]), 32'h0000);
            chk("b2b_m0", 32'(lg_mode[0]), 32'd1);
            chk("b2b_m1", 32'(lg_mode[1]), 32'd0);
            chk("b2b_m2", 32'(lg_mode[2]), 32'd1);
        end
`ifdef COUNT_SEQ_DONECNT_EN
        chk("b2b_done_cnt", 32'(done_cnt - base), 32'd3);
`endif

        // Backpressure with a long first command
        clear_log();
        bp_val[0] = 16'h0100;
        bp_run[0] = 8'd200;
        for (int i = 1; i < 6; i++) begin
            bp_val[i] = 16'h0200 + 16'(i);
            bp_run[i] = 8'd0;
        end
        n_acc = 0;
        blocked_at = -1;
        n = 0;
        while (n_acc < 6 && n < 400) begin
            logic acc;
            bus.cmd_valid = 1'b1;
            bus.cmd_mode  = 1'b1;
            bus.cmd_value = bp_val[n_acc];
            bus.cmd_run   = bp_run[n_acc];
            acc = bus.cmd_ready;
            if (!acc && blocked_at < 0) blocked_at = n_acc;
            tick();
            if (acc) n_acc++;
            n++;
        end
        bus.cmd_valid = 1'b0;
        chk("bp_accepts_before_full", 32'(blocked_at), 32'(DEPTH + 1));
        chk("bp_all_accepted", 32'(n_acc), 32'd6);
        wait_idle(400);
        chk("bp_pulses", 32'(lg_dat.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < lg_dat.size()) chk("bp_order", 32'(lg_dat[i]), 32'(bp_val[i]));
        end
        chk("bp_ready_after", 32'(bus.cmd_ready), 32'd1);

        // Streamed commands against a counter reference
        runs = '{8'd0, 8'd2, 8'd0, 8'd1, 8'd3, 8'd0, 8'd0, 8'd2, 8'd1, 8'd0, 8'd3, 8'd0};
        wexp.delete();
        for (int i = 0; i < 3 * DEPTH; i++) begin
            logic [15:0] v;
            v = (i == 4) ? 16'hFFFE : (i == 10) ? 16'h0001 : 16'(i * 16'h1111);
            wexp.push_back(v);
            for (int j = 1; j <= int'(runs[i]); j++)
                wexp.push_back((i % 2 == 0) ? v + 16'(j) : v - 16'(j));
        end
        widx = 0;
        wrap_on = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            logic [15:0] v;
            v = (i == 4) ? 16'hFFFE : (i == 10) ? 16'h0001 : 16'(i * 16'h1111);
            push_cmd((i % 2 == 0), v, runs[i], acc_e);
        end
        wait_idle(100);
        wrap_on = 1'b0;
        chk("wrap_len", 32'(widx), 32'(wexp.size()));

        // Reset while a command is running with more queued
        clear_log();
        push_cmd(1'b1, 16'h5555, 8'd50, acc_e);
        push_cmd(1'b0, 16'h6666, 8'd0, acc_e);
        push_cmd(1'b1, 16'h7777, 8'd0, acc_e);
        tick();
        tick();
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_data", 32'(bus.data_in), 32'h0);
        chk("mid_rst_load", 32'(bus.load), 32'h0);
        chk("mid_rst_mode", 32'(bus.mode), 32'h0);
        chk("mid_rst_busy", 32'(bus.busy), 32'h0);
        chk("mid_rst_ready", 32'(bus.cmd_ready), 32'h1);
        @(negedge clk);
        clear_log();
        reset = 1'b0;
        for (int i = 0; i < 80; i++) tick();
        chk("rst_no_replay", 32'(lg_dat.size()), 32'd0);
        chk("rst_idle", 32'(bus.busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/count_cmd_seq.md
# count_cmd_seq

Command sequencer that sits directly upstream of the 16-bit loadable up/down counter and drives its `data_in`, `load` and `mode` inputs. It accepts queued commands (start value, direction, run length) over a valid/ready port, buffers them in a small FIFO, and plays each back as a one-cycle load followed by a programmed number of free-counting cycles. Commands execute back-to-back with no idle cycle between them.

## Interface
Parameters:
- `DATA_W`, 16, counter data width; matches the counter's `data_in` width.
- `DEPTH`, 4, command FIFO depth; must be a power of two and at least 2.
- `RUN_W`, 8, width of the run-length field.

Ports:
- `clk`, in, 1, single clock; all logic is on its rising edge.
- `reset`, in, 1, asynchronous, active-high reset.
- `cmd_valid`, in, 1, command offered.
- `cmd_ready`, out, 1, sequencer can accept a command; equals `!fifo_full`.
- `cmd_mode`, in, 1, counting direction: 1 = up, 0 = down.
- `cmd_value`, in, DATA_W, value to load into the counter.
- `cmd_run`, in, RUN_W, number of counting cycles after the load; 0 means load only.
- `data_in`, out, DATA_W, counter load value (registered).
- `load`, out, 1, counter load strobe (registered).
- `mode`, out, 1, counter direction (registered).
- `busy`, out, 1, FSM is not in IDLE.
- `cmd_done_cnt`, out, 16, number of completed commands. Present only when `COUNT_SEQ_DONECNT_EN` is defined.

## Operation
- **Command accept.** A command is accepted when `cmd_valid && cmd_ready` on a rising edge; {mode, value, run} is pushed into the FIFO.
- **Backpressure.** `cmd_ready` is 0 whenever the FIFO is full, even if a pop happens in the same cycle. A full FIFO therefore takes no push.
- **FSM states.** IDLE, LOAD, RUN.
- **IDLE:**
  - FIFO non-empty: pop, register `load`=1, `data_in`=value, `mode`=mode, run counter=run, and go to LOAD.
  - Otherwise: stay in IDLE.
- **LOAD** (one cycle, with `load`=1 visible):
  - run ≠ 0: go to RUN with `load`=0.
  - run = 0 and FIFO non-empty: pop the next command and stay in LOAD.
  - run = 0 and FIFO empty: go to IDLE.
- **RUN:**
  - `load`=0 and `mode` is held; the run counter decrements each cycle.
  - When the counter equals 1: pop-and-LOAD if the FIFO is non-empty, else go to IDLE.
- **Idle outputs.** In IDLE, `data_in` and `mode` hold their last values and `load`=0.
- **Output policy.** `data_in` and `mode` change only in the cycle in which `load` rises.
- **Simultaneous push and pop.** Both happen in the same cycle, so the occupancy count is unchanged. A push into an empty FIFO is visible to the FSM on the next edge (no bypass path).
- **Pointer wrap.** Read and write pointers wrap modulo DEPTH. Full and empty are distinguished by an extra pointer bit.

## Timing
- **Reset values.** `data_in`=0, `load`=0, `mode`=0, `busy`=0, `cmd_ready`=1, `cmd_done_cnt`=0. The FIFO is emptied and the FSM is forced to IDLE.
- **Reset mid-command.** The command is abandoned, all queued commands are discarded, and outputs return to reset values asynchronously.
- **Latency.** A command handshaken at edge k into an empty, idle sequencer produces `load`=1 during the cycle after edge k+1.
- **Command duration.** Each command occupies exactly 1 + run cycles. The next command's `load` follows in the very next cycle if it is queued.
- **Output timing.** All outputs are registers, so there is no combinational path from `cmd_*` to counter outputs. The one exception is `cmd_ready`, which derives from the registered FIFO count.

## Configuration
- **Macro:** `COUNT_SEQ_DONECNT_EN`.
- **Defined:**
  - Adds the `cmd_done_cnt` port, a 16-bit counter.
  - Increments once per command on its final cycle: the LOAD cycle when run = 0, otherwise the last RUN cycle.
  - Wraps from 0xFFFF to 0.
- **Undefined:** the port and its counter are absent, and all other behaviour is identical.

## Structure
- **Package `count_seq_pkg`** holds:
  - the `state_e` enum {IDLE, LOAD, RUN};
  - the `cmd_t` packed struct {mode, value, run};
  - the default width localparams.
- **Sub-module `count_cmd_fifo`:**
  - synchronous FIFO of `cmd_t`, DEPTH entries;
  - ports: push, pop, wdata, rdata, full, empty.
- **Top level** holds the FSM, the run counter and the output registers.

## Test plan
- **Reset.** Assert `reset` mid-RUN → outputs go to 0 at once, `cmd_ready`=1, `busy`=0; queued commands never execute.
- **Single command.** Push {up, 0x1234, run=3} → one cycle of `load`=1 with `data_in`=0x1234 and `mode`=1, then exactly 3 cycles of `load`=0, then `busy`=0.
- **Back-to-back commands.** Push {up, 0x0010, 2}, {down, 0xFFFF, 0}, {up, 0x0000, 1} → `load` pulses at relative cycles 0, 3, 4 with no idle cycle between them; `mode` sequence 1, 0, 1.
- **Full/backpressure.** Hold `cmd_valid`=1 with DEPTH+2 commands while the first has run=200 → `cmd_ready` falls after DEPTH+1 accepts (one command is in progress plus DEPTH queued); no command is lost or duplicated.
- **Wrap-around.** Stream 3·DEPTH commands with mixed run=0 and run>0 against a reference model of the counter → the counter's `data_out` matches the model every cycle.
- **Done counter (`COUNT_SEQ_DONECNT_EN` defined).** After the back-to-back scenario, `cmd_done_cnt`=3; it wraps to 0 after 65536 completions.
